// File: rtl/exu_pkg.sv
// rtl/exu_pkg.sv - shared encodings and types for the execution-unit writeback path
`ifndef RV_XLEN
`define RV_XLEN 32
`endif
`ifndef RV_GPR_AW
`define RV_GPR_AW 5
`endif

package exu_pkg;

  localparam int EXU_ARB_FIXED = 0;
  localparam int EXU_ARB_RR    = 1;

  typedef struct packed {
    logic [`RV_GPR_AW-1:0] waddr;
    logic [`RV_XLEN-1:0]   wdata;
  } wb_req_t;

endpackage

// File: rtl/exu_rr_arb.sv
// rtl/exu_rr_arb.sv - N-way one-hot priority pick with a round-robin pointer
// In fixed mode the pointer never leaves zero, so the pick degenerates to lowest-index-first.
module exu_rr_arb
  import exu_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int ARB_MODE = EXU_ARB_RR,
  localparam int PW      = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req_i,
  output logic [N_CH-1:0] gnt_o
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win;
  logic [PW:0]   cand;
  logic          found;
  logic [N_CH-1:0] gnt;

  // Walk the channels starting at the pointer, wrapping explicitly so
  // non-power-of-two channel counts stay in range.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(N_CH)) begin
        cand = cand - (PW+1)'(N_CH);
      end
      if (!found && req_i[cand[PW-1:0]]) begin
        found = 1'b1;
        win   = cand[PW-1:0];
      end
    end
    if (found) begin
      gnt[win] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      if (ARB_MODE == EXU_ARB_RR) begin
        ptr_d = (win == PW'(N_CH - 1)) ? '0 : win + PW'(1);
      end else begin
        ptr_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign gnt_o = gnt;

endmodule

// File: rtl/exu_wb_arb.sv
// rtl/exu_wb_arb.sv - N-channel writeback arbiter feeding the GPR write port
// Grants are combinational; the selected write is registered for one cycle and published for hazard checks.
`ifndef RV_XLEN
`define RV_XLEN 32
`endif
`ifndef RV_GPR_AW
`define RV_GPR_AW 5
`endif

module exu_wb_arb
  import exu_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int XLEN     = `RV_XLEN,
  parameter int GPR_AW   = `RV_GPR_AW,
  parameter int ARB_MODE = EXU_ARB_RR,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        ch_vld,
  output logic [N_CH-1:0]        ch_rdy,
  input  logic [N_CH*GPR_AW-1:0] ch_waddr,
  input  logic [N_CH*XLEN-1:0]   ch_wdata,
  output logic                   gpr_wen,
  output logic [GPR_AW-1:0]      gpr_waddr,
  output logic [XLEN-1:0]        gpr_wdata,
  output logic                   pend_vld,
  output logic [GPR_AW-1:0]      pend_addr,
  output logic [CNT_W-1:0]       conflict_cnt,
  input  logic                   cnt_clr
);

  logic [N_CH-1:0]   gnt;
  logic              hs;
  logic              multi_req;
  logic [GPR_AW-1:0] sel_addr;
  logic [XLEN-1:0]   sel_data;

  logic              wen_q, wen_d;
  logic [GPR_AW-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  exu_rr_arb #(
    .N_CH     (N_CH),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (ch_vld),
    .gnt_o (gnt)
  );

  assign ch_rdy = gnt;
  assign hs     = |gnt;

  // Clearing the lowest set bit leaves something only when two or more requested.
  assign multi_req = |(ch_vld & (ch_vld - N_CH'(1)));

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      sel_addr = sel_addr | (ch_waddr[i*GPR_AW +: GPR_AW] & {GPR_AW{gnt[i]}});
      sel_data = sel_data | (ch_wdata[i*XLEN +: XLEN] & {XLEN{gnt[i]}});
    end
  end

  always_comb begin
    wen_d   = hs && (sel_addr != '0);
    waddr_d = hs ? sel_addr : waddr_q;
    wdata_d = hs ? sel_data : wdata_q;
    cnt_d   = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (multi_req && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gpr_wen      = wen_q;
  assign gpr_waddr    = waddr_q;
  assign gpr_wdata    = wdata_q;
  assign pend_vld     = wen_q;
  assign pend_addr    = waddr_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_exu_wb_arb.sv
// tb/tb_exu_wb_arb.sv - bench for exu_wb_arb: RR N=4, fixed N=4 with 2-bit counter, RR N=3
module tb_exu_wb_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [3:0]   vld [3];
  logic [19:0]  wa  [3];
  logic [127:0] wd  [3];
  logic         clr [3];

  wire [3:0]  rdy [3];
  wire        wen [3];
  wire [4:0]  ga  [3];
  wire [31:0] gd  [3];
  wire        pv  [3];
  wire [4:0]  pa  [3];
  wire [15:0] cnt [3];
  wire [2:0]  rdy_c;
  wire [1:0]  cnt_b;

  assign rdy[2] = {1'b0, rdy_c};
  assign cnt[1] = {14'b0, cnt_b};

  exu_wb_arb #(.N_CH(4), .XLEN(32), .GPR_AW(5), .ARB_MODE(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .ch_vld(vld[0]), .ch_rdy(rdy[0]), .ch_waddr(wa[0]), .ch_wdata(wd[0]),
    .gpr_wen(wen[0]), .gpr_waddr(ga[0]), .gpr_wdata(gd[0]), .pend_vld(pv[0]), .pend_addr(pa[0]),
    .conflict_cnt(cnt[0]), .cnt_clr(clr[0]));

  exu_wb_arb #(.N_CH(4), .XLEN(32), .GPR_AW(5), .ARB_MODE(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .ch_vld(vld[1]), .ch_rdy(rdy[1]), .ch_waddr(wa[1]), .ch_wdata(wd[1]),
    .gpr_wen(wen[1]), .gpr_waddr(ga[1]), .gpr_wdata(gd[1]), .pend_vld(pv[1]), .pend_addr(pa[1]),
    .conflict_cnt(cnt_b), .cnt_clr(clr[1]));

  exu_wb_arb #(.N_CH(3), .XLEN(32), .GPR_AW(5), .ARB_MODE(1), .CNT_W(16)) dut_c (
    .clk(clk), .rst(rst), .ch_vld(vld[2][2:0]), .ch_rdy(rdy_c), .ch_waddr(wa[2][14:0]),
    .ch_wdata(wd[2][95:0]), .gpr_wen(wen[2]), .gpr_waddr(ga[2]), .gpr_wdata(gd[2]),
    .pend_vld(pv[2]), .pend_addr(pa[2]), .conflict_cnt(cnt[2]), .cnt_clr(clr[2]));

  localparam int NCH  [3] = '{4, 4, 3};
  localparam bit RR   [3] = '{1'b1, 1'b0, 1'b1};
  localparam int CMAX [3] = '{65535, 3, 65535};

  int          checks = 0;
  int          failures = 0;
  int          m_ptr  [3];
  int          m_cnt  [3];
  bit          e_wen  [3];
  logic [4:0]  e_wa   [3];
  logic [31:0] e_wd   [3];
  int          last_g [3];

  // Reference pick: scan from the priority point, modulo channel count.
  function automatic int pick(input int d);
    int s;
    int c;
    s = RR[d] ? m_ptr[d] : 0;
    for (int i = 0; i < NCH[d]; i++) begin
      c = (s + i) % NCH[d];
      if (vld[d][c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_rdy(input int d);
    int g;
    g = pick(d);
    if (g < 0) return 4'b0000;
    return 4'b0001 << g;
  endfunction

  task automatic tick();
    int g;
    for (int d = 0; d < 3; d++) begin
      g = pick(d);
      last_g[d] = g;
      if (rst) begin
        m_ptr[d] = 0; m_cnt[d] = 0; e_wen[d] = 1'b0; e_wa[d] = '0; e_wd[d] = '0;
      end else begin
        if (g >= 0) begin
          if (RR[d]) m_ptr[d] = (g + 1) % NCH[d];
          e_wa[d]  = wa[d][g*5 +: 5];
          e_wd[d]  = wd[d][g*32 +: 32];
          e_wen[d] = (e_wa[d] != 0);
        end else begin
          e_wen[d] = 1'b0;
        end
        if (clr[d]) m_cnt[d] = 0;
        else if ($countones(vld[d]) >= 2 && m_cnt[d] < CMAX[d]) m_cnt[d] = m_cnt[d] + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int d = 0; d < 3; d++) begin
      vld[d] = '0; wa[d] = '0; wd[d] = '0; clr[d] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      if ({wen[d], pv[d]} !== 2'b00) begin
        $display("FAIL reset_wen[%0d]: got %b want 00", d, {wen[d], pv[d]}); failures++;
      end
      checks++;
      if ({ga[d], pa[d], gd[d]} !== 42'd0) begin
        $display("FAIL reset_addr_data[%0d]: got %h want 0", d, {ga[d], pa[d], gd[d]}); failures++;
      end
      checks++;
      if (cnt[d] !== 16'd0) begin
        $display("FAIL reset_cnt[%0d]: got %0d want 0", d, cnt[d]); failures++;
      end
      checks++;
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    idle();
    vld[0] = 4'b0100;
    wa[0][14:10] = 5'd5;
    wd[0][95:64] = 32'hDEADBEEF;
    #1;
    if (rdy[0] !== 4'b0100) begin
      $display("FAIL single_rdy: got %b want 0100", rdy[0]); failures++;
    end
    checks++;
    tick();
    if ({wen[0], pv[0], ga[0], pa[0], gd[0]} !== {1'b1, 1'b1, 5'd5, 5'd5, 32'hDEADBEEF}) begin
      $display("FAIL single_wb: got wen=%b pv=%b a=%0d pa=%0d d=%h want 1 1 5 5 deadbeef",
               wen[0], pv[0], ga[0], pa[0], gd[0]);
      failures++;
    end
    checks++;
    vld[0] = 4'b0000;
    tick();
    if ({wen[0], ga[0], gd[0]} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
      $display("FAIL single_hold: got wen=%b a=%0d d=%h want 0 5 deadbeef", wen[0], ga[0], gd[0]);
      failures++;
    end
    checks++;
  endtask

  task automatic test_rr_fair();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    vld[0] = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      wa[0][c*5 +: 5]   = 5'(c + 1);
      wd[0][c*32 +: 32] = 32'h1000 + 32'(c);
    end
    for (int i = 0; i < 8; i++) begin
      #1;
      if (rdy[0] !== (4'b0001 << (i % 4))) begin
        $display("FAIL rr_fair_gnt[%0d]: got %b want %b", i, rdy[0], 4'b0001 << (i % 4)); failures++;
      end
      checks++;
      tick();
      if ({wen[0], ga[0]} !== {1'b1, 5'((i % 4) + 1)}) begin
        $display("FAIL rr_fair_wb[%0d]: got wen=%b a=%0d want 1 %0d", i, wen[0], ga[0], (i % 4) + 1);
        failures++;
      end
      checks++;
    end
    vld[0] = 4'b0000;
    if (cnt[0] !== 16'd8) begin
      $display("FAIL rr_fair_cnt: got %0d want 8", cnt[0]); failures++;
    end
    checks++;
  endtask

  task automatic test_fixed_sat();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    vld[1] = 4'b1010;
    wa[1][9:5] = 5'd11;
    wa[1][19:15] = 5'd13;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (rdy[1] !== 4'b0010) begin
        $display("FAIL fixed_gnt[%0d]: got %b want 0010", i, rdy[1]); failures++;
      end
      checks++;
      tick();
      if ({wen[1], ga[1]} !== {1'b1, 5'd11}) begin
        $display("FAIL fixed_wb[%0d]: got wen=%b a=%0d want 1 11", i, wen[1], ga[1]); failures++;
      end
      checks++;
    end
    if (cnt[1] !== 16'd3) begin
      $display("FAIL fixed_cnt_sat: got %0d want 3", cnt[1]); failures++;
    end
    checks++;
    clr[1] = 1'b1;
    tick();
    clr[1] = 1'b0;
    vld[1] = 4'b0000;
    if (cnt[1] !== 16'd0) begin
      $display("FAIL fixed_cnt_clr: got %0d want 0", cnt[1]); failures++;
    end
    checks++;
  endtask

  task automatic test_x0();
    idle();
    vld[0] = 4'b0100;
    wd[0][95:64] = 32'hCAFE0001;
    #1;
    if (rdy[0] !== 4'b0100) begin
      $display("FAIL x0_rdy: got %b want 0100", rdy[0]); failures++;
    end
    checks++;
    tick();
    if ({wen[0], pv[0], ga[0], gd[0]} !== {1'b0, 1'b0, 5'd0, 32'hCAFE0001}) begin
      $display("FAIL x0_wb: got wen=%b pv=%b a=%0d d=%h want 0 0 0 cafe0001", wen[0], pv[0], ga[0], gd[0]);
      failures++;
    end
    checks++;
  endtask

  task automatic test_wrap_n3();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    vld[2] = 4'b0100;
    #1;
    if (rdy[2] !== 4'b0100) begin
      $display("FAIL wrap_first: got %b want 0100", rdy[2]); failures++;
    end
    checks++;
    tick();
    vld[2] = 4'b0011;
    #1;
    if (rdy[2] !== 4'b0001) begin
      $display("FAIL wrap_second: got %b want 0001", rdy[2]); failures++;
    end
    checks++;
    tick();
  endtask

  task automatic test_reset_midflight();
    idle();
    tick();
    vld[0] = 4'b0001;
    wa[0][4:0] = 5'd7;
    wd[0][31:0] = 32'h0BADF00D;
    #1;
    if (rdy[0] !== exp_rdy(0)) begin
      $display("FAIL mid_first_rdy: got %b want %b", rdy[0], exp_rdy(0)); failures++;
    end
    checks++;
    tick();
    if ({wen[0], ga[0]} !== {1'b1, 5'd7}) begin
      $display("FAIL mid_inflight: got wen=%b a=%0d want 1 7", wen[0], ga[0]); failures++;
    end
    checks++;
    vld[0] = 4'b0010;
    wa[0][9:5] = 5'd9;
    rst = 1'b1;
    #1;
    if (rdy[0] !== 4'b0010) begin
      $display("FAIL mid_rst_rdy: got %b want 0010", rdy[0]); failures++;
    end
    checks++;
    tick();
    rst = 1'b0;
    if ({wen[0], pv[0], ga[0], pa[0], gd[0], cnt[0]} !== 60'd0) begin
      $display("FAIL mid_rst_outputs: got wen=%b pv=%b a=%0d pa=%0d d=%h cnt=%0d want all 0",
               wen[0], pv[0], ga[0], pa[0], gd[0], cnt[0]);
      failures++;
    end
    checks++;
    idle();
  endtask

  task automatic test_random();
    bit          pend [3][4];
    logic [4:0]  pad  [3][4];
    logic [31:0] pdt  [3][4];
    bit          r;
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < 4; c++) begin
        pend[d][c] = 1'b0; pad[d][c] = '0; pdt[d][c] = '0;
      end
    for (int n = 0; n < 600; n++) begin
      r = ($urandom_range(0, 96) == 0);
      rst = r;
      for (int d = 0; d < 3; d++) begin
        for (int c = 0; c < 4; c++) begin
          if (c < NCH[d] && !pend[d][c] && $urandom_range(0, 2) == 0) begin
            pend[d][c] = 1'b1;
            pad[d][c]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            pdt[d][c]  = $urandom;
          end
          vld[d][c]         = pend[d][c];
          wa[d][c*5 +: 5]   = pad[d][c];
          wd[d][c*32 +: 32] = pdt[d][c];
        end
        clr[d] = ($urandom_range(0, 31) == 0);
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        if (rdy[d] !== exp_rdy(d)) begin
          $display("FAIL rand_rdy[%0d] n=%0d: got %b want %b", d, n, rdy[d], exp_rdy(d)); failures++;
        end
        checks++;
      end
      tick();
      for (int d = 0; d < 3; d++) begin
        if ({wen[d], pv[d], ga[d], pa[d], gd[d]} !== {e_wen[d], e_wen[d], e_wa[d], e_wa[d], e_wd[d]}) begin
          $display("FAIL rand_wb[%0d] n=%0d: got wen=%b pv=%b a=%0d pa=%0d d=%h want %b %b %0d %0d %h",
                   d, n, wen[d], pv[d], ga[d], pa[d], gd[d], e_wen[d], e_wen[d], e_wa[d], e_wa[d], e_wd[d]);
          failures++;
        end
        checks++;
        if (cnt[d] !== 16'(m_cnt[d])) begin
          $display("FAIL rand_cnt[%0d] n=%0d: got %0d want %0d", d, n, cnt[d], m_cnt[d]); failures++;
        end
        checks++;
        if (!r && last_g[d] >= 0) pend[d][last_g[d]] = 1'b0;
      end
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_single();
    test_rr_fair();
    test_fixed_sat();
    test_x0();
    test_wrap_n3();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
